// File: rtl/hand_pkt_pkg.sv
// Shared constants and FSM state type for the hand-coordinate packet receiver.
package hand_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hFF;
    localparam int         PAYLOAD_LEN = 6;
    localparam int         COORD_W     = 12;

    typedef enum logic {
        HUNT,
        PAYLOAD
    } pkt_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling, stop-bit check.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 564
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int HALF_BIT = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_last;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // rx_last lags rx_sync by one cycle so a high-to-low step marks a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_last    <= 1'b1;
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            rx_meta    <= rxd;
            rx_sync    <= rx_meta;
            rx_last    <= rx_sync;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_last && !rx_sync) begin
                        rx_state <= RX_START;
                        cnt      <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == CNT_W'(HALF_BIT - 1)) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt      <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            data       <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            byte_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hand_packet_receiver.sv
// Hunts for an 0xFF sync preamble, assembles a six-byte coordinate payload and
// latches four 12-bit hand coordinates; flags stale data when packets stop.
module hand_packet_receiver
    import hand_pkt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 564,
    parameter int SYNC_LEN     = 3,
    parameter int STALE_CYCLES = 4_194_304
) (
    input  logic               clk_65mhz,
    input  logic               sys_rst,
    input  logic               rxd_in,
    output logic [COORD_W-1:0] hand_x_left_top,
    output logic [COORD_W-1:0] hand_y_left_top,
    output logic [COORD_W-1:0] hand_x_left_bottom,
    output logic [COORD_W-1:0] hand_y_left_bottom,
    output logic               coords_valid,
    output logic               frame_err,
    output logic               stale
);

    localparam int SYNC_W  = $clog2(SYNC_LEN + 1);
    localparam int IDX_W   = $clog2(PAYLOAD_LEN);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);
    localparam int ABORT_IDX = 3;

    logic [7:0] rx_data;
    logic       byte_valid;
    logic       byte_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk_65mhz),
        .rst       (sys_rst),
        .rxd       (rxd_in),
        .data      (rx_data),
        .byte_valid(byte_valid),
        .byte_err  (byte_err)
    );

    pkt_state_t          state;
    logic [SYNC_W-1:0]   sync_cnt;
    logic [IDX_W-1:0]    idx;
    logic [7:0]          pay [0:PAYLOAD_LEN-2];
    logic [STALE_W-1:0]  stale_cnt;

    // P5 is never stored: the final byte is consumed straight from the receiver
    // so all four coordinates update together one cycle after it arrives.
    always_ff @(posedge clk_65mhz or posedge sys_rst) begin
        if (sys_rst) begin
            state              <= HUNT;
            sync_cnt           <= '0;
            idx                <= '0;
            for (int i = 0; i < PAYLOAD_LEN - 1; i++) begin
                pay[i] <= '0;
            end
            hand_x_left_top    <= '0;
            hand_y_left_top    <= '0;
            hand_x_left_bottom <= '0;
            hand_y_left_bottom <= '0;
            coords_valid       <= 1'b0;
            frame_err          <= 1'b0;
            stale_cnt          <= STALE_W'(STALE_CYCLES);
        end else begin
            coords_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (stale_cnt != STALE_W'(STALE_CYCLES)) begin
                stale_cnt <= stale_cnt + 1'b1;
            end
            if (byte_err) begin
                frame_err <= 1'b1;
                state     <= HUNT;
                sync_cnt  <= '0;
                idx       <= '0;
            end else if (byte_valid) begin
                if (state == HUNT) begin
                    if (rx_data == SYNC_BYTE) begin
                        if (sync_cnt != SYNC_W'(SYNC_LEN)) begin
                            sync_cnt <= sync_cnt + 1'b1;
                        end
                    end else if (sync_cnt == SYNC_W'(SYNC_LEN)) begin
                        pay[0]   <= rx_data;
                        idx      <= IDX_W'(1);
                        sync_cnt <= '0;
                        state    <= PAYLOAD;
                    end else begin
                        sync_cnt <= '0;
                    end
                end else begin
                    // An 0xFF where P3 belongs means a new preamble has started.
                    if (idx == IDX_W'(ABORT_IDX) && rx_data == SYNC_BYTE) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                        sync_cnt  <= SYNC_W'(1);
                        idx       <= '0;
                    end else if (idx == IDX_W'(PAYLOAD_LEN - 1)) begin
                        hand_x_left_top    <= {pay[0], pay[2][7:4]};
                        hand_y_left_top    <= {pay[2][3:0], pay[1]};
                        hand_x_left_bottom <= {pay[3], rx_data[7:4]};
                        hand_y_left_bottom <= {rx_data[3:0], pay[4]};
                        coords_valid       <= 1'b1;
                        stale_cnt          <= '0;
                        state              <= HUNT;
                        sync_cnt           <= '0;
                        idx                <= '0;
                    end else begin
                        pay[idx] <= rx_data;
                        idx      <= idx + 1'b1;
                    end
                end
            end
        end
    end

    assign stale = (stale_cnt == STALE_W'(STALE_CYCLES));

endmodule

// File: tb/tb_hand_packet_receiver.sv
// Scoreboard bench for hand_packet_receiver: directed UART packets, queued expectations.
module tb_hand_packet_receiver;

    localparam int CPB   = 16;
    localparam int STALE = 1000;

    logic        clk;
    logic        sys_rst;
    logic        rxd;
    logic [11:0] xt, yt, xb, yb;
    logic        coords_valid, frame_err, stale;

    hand_packet_receiver #(
        .CLKS_PER_BIT(CPB),
        .SYNC_LEN    (3),
        .STALE_CYCLES(STALE)
    ) dut (
        .clk_65mhz         (clk),
        .sys_rst           (sys_rst),
        .rxd_in            (rxd),
        .hand_x_left_top   (xt),
        .hand_y_left_top   (yt),
        .hand_x_left_bottom(xb),
        .hand_y_left_bottom(yb),
        .coords_valid      (coords_valid),
        .frame_err         (frame_err),
        .stale             (stale)
    );

    typedef struct packed {
        logic        is_coords;
        logic [11:0] xt, yt, xb, yb;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] tx_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_commit = 0;
    logic [11:0] held_xt = 0, held_yt = 0, held_xb = 0, held_yb = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_coords(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c, input logic [11:0] d);
        held_xt = a; held_yt = b; held_xb = c; held_yb = d;
        sb.push_back('{1'b1, a, b, c, d});
    endtask

    task automatic push_err();
        sb.push_back('{1'b0, held_xt, held_yt, held_xb, held_yb});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge clk);
        if (bad_stop) begin
            rxd = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Sends tx_q back to back; the byte at bad_idx gets a zero stop bit.
    task automatic apply_stimulus(input int bad_idx);
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], i == bad_idx);
        end
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!sys_rst && (coords_valid || frame_err)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pulse: got coords_valid=%0b frame_err=%0b expected no pulse",
                         coords_valid, frame_err);
            end else begin
                mon_e = sb.pop_front();
                check_output("coords_valid", {31'd0, coords_valid}, {31'd0, mon_e.is_coords});
                check_output("frame_err", {31'd0, frame_err}, {31'd0, !mon_e.is_coords});
                check_output("x_top", {20'd0, xt}, {20'd0, mon_e.xt});
                check_output("y_top", {20'd0, yt}, {20'd0, mon_e.yt});
                check_output("x_bot", {20'd0, xb}, {20'd0, mon_e.xb});
                check_output("y_bot", {20'd0, yb}, {20'd0, mon_e.yb});
                if (coords_valid) last_commit = cyc;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        total++;
        bad++;
        $display("[TB] FAIL timeout: got no end of test expected finish within 60000 cycles");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rxd     = 1'b1;
        sys_rst = 1'b1;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_x_top", {20'd0, xt}, 32'd0);
        check_output("rst_y_bot", {20'd0, yb}, 32'd0);
        check_output("rst_coords_valid", {31'd0, coords_valid}, 32'd0);
        check_output("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_output("rst_stale", {31'd0, stale}, 32'd1);

        $display("[TB] good packet");
        push_coords(12'h205, 12'h134, 12'h10A, 12'h278);
        tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'h20, 8'h34, 8'h51, 8'h10, 8'h78, 8'hA2};
        apply_stimulus(-1);
        check_output("stale_after_pkt", {31'd0, stale}, 32'd0);

        $display("[TB] stale timeout");
        while (cyc < last_commit + STALE - 5) @(negedge clk);
        check_output("stale_before_limit", {31'd0, stale}, 32'd0);
        while (cyc < last_commit + STALE + 5) @(negedge clk);
        check_output("stale_at_limit", {31'd0, stale}, 32'd1);

        $display("[TB] extra sync bytes");
        push_coords(12'h205, 12'h134, 12'h10A, 12'h278);
        tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h20, 8'h34, 8'h51, 8'h10, 8'h78, 8'hA2};
        apply_stimulus(-1);

        $display("[TB] stop-bit error on P2");
        push_err();
        tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'h20, 8'h34, 8'h51, 8'h10, 8'h78, 8'hA2};
        apply_stimulus(5);
        push_coords(12'hABE, 12'hFCD, 12'h125, 12'h634);
        tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56};
        apply_stimulus(-1);

        $display("[TB] resync on 0xFF at P3");
        push_err();
        push_coords(12'h300, 12'h000, 12'h000, 12'h000);
        tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'h20, 8'h34, 8'h51, 8'hFF, 8'hFF, 8'hFF,
                 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        apply_stimulus(-1);

        $display("[TB] reset mid-payload");
        push_coords(12'h205, 12'h134, 12'h10A, 12'h278);
        tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'h20, 8'h34, 8'h51, 8'h10, 8'h78, 8'hA2};
        apply_stimulus(-1);
        tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h22};
        for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b0);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        sys_rst = 1'b1;
        #1;
        check_output("mid_rst_x_top", {20'd0, xt}, 32'd0);
        check_output("mid_rst_y_top", {20'd0, yt}, 32'd0);
        check_output("mid_rst_x_bot", {20'd0, xb}, 32'd0);
        check_output("mid_rst_y_bot", {20'd0, yb}, 32'd0);
        check_output("mid_rst_stale", {31'd0, stale}, 32'd1);
        check_output("mid_rst_coords_valid", {31'd0, coords_valid}, 32'd0);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        sys_rst = 1'b0;
        held_xt = 0; held_yt = 0; held_xb = 0; held_yb = 0;
        repeat (3 * CPB) @(negedge clk);

        $display("[TB] good packet after reset");
        push_coords(12'h205, 12'h134, 12'h10A, 12'h278);
        tx_q = '{8'hFF, 8'hFF, 8'hFF, 8'h20, 8'h34, 8'h51, 8'h10, 8'h78, 8'hA2};
        apply_stimulus(-1);

        repeat (20) @(negedge clk);
        check_output("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
